sasa_scan_cam: RTL and testbench
================================

Name: sasa_scan_cam

Overview:
- Parametrised successor of the SASA match-vector CAM. It walks an N x N quantised score matrix through the data_req / data_addr_x / data_addr_y fetch handshake.
- Optional pass 1 per row finds the row maximum. Pass 2 converts each element, raw or max-subtracted, into a one-hot match vector.
- Results stream through a 2-entry output FIFO with valid/ready backpressure.
- Sits between the score-matrix source and the softmax LUT stage.

Parameters:
N, 16, matrix dimension (rows = columns); power of 2, >= 2
DATA_W, 8, signed element width (Q4.4 at default)
ADDR_W, $clog2(N), width of address and coordinate outputs
MV_W, 2**DATA_W, match-vector width (256 at default)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a full matrix scan; ignored unless IDLE or DONE
mode  in  1  0 = raw, 1 = max-subtracted; sampled with start, held for the whole scan
data_req  out  1  fetch request (registered)
data_addr_x  out  ADDR_W  column of requested element (registered)
data_addr_y  out  ADDR_W  row of requested element (registered)
data  in  DATA_W  signed element; sampled on the rising edge that ends a data_req cycle
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head when out_valid & out_ready
out_match  out  MV_W  one-hot, bit out_idx set
out_idx  out  DATA_W  unsigned match index
out_x  out  ADDR_W  element column
out_y  out  ADDR_W  element row
out_row_max  out  DATA_W  row maximum used (0 in mode 0)
finish  out  1  level; high in DONE

Behaviour:
- Reset, on the clock edge with reset=1:
  - State goes to IDLE; FIFO is emptied.
  - Outputs: data_req=0, addresses=0, out_valid=0, out_match=0, out_idx=0, out_x=0, out_y=0, out_row_max=0, finish=0.
  - Reset wins over every other input in the same cycle. Reset mid-scan abandons the scan; nothing resumes.
- Fetch timing: with data_req=1 in cycle k, data is captured at the edge closing cycle k, so one element completes per request cycle. data is don't-care (may be Z) when data_req=0.
- States:
  - IDLE: on start go to MAX if mode=1, else EMIT, with row=0 and col=0.
  - MAX: data_req=1 every cycle, col 0..N-1.
    - rmax is initialised to -2^(DATA_W-1) on row entry; rmax=max(rmax,data) signed on each capture.
    - After the col=N-1 capture, go to EMIT for the same row, col=0.
  - EMIT: data_req=1 in a cycle only if FIFO occupancy at the start of that cycle is <=1, so the FIFO never overflows.
    - Each capture pushes {idx, one-hot, col, row, rmax}.
    - After col=N-1: if row<N-1, then row++ and go to MAX (mode 1) or stay in EMIT (mode 0); else go to DRAIN.
  - DRAIN: no requests; go to DONE when the FIFO is empty.
  - DONE: finish=1. start clears finish on the next cycle and restarts as from IDLE.
- Index arithmetic:
  - Mode 0: idx = data + 2^(DATA_W-1), computed unsigned, range 0..MV_W-1.
  - Mode 1: diff = data - rmax, computed in DATA_W+1 bits, always <=0.
    - If diff < -2^(DATA_W-1), saturate to -2^(DATA_W-1).
    - idx = diff + 2^(DATA_W-1), range 0..2^(DATA_W-1).
  - out_match = 1 << idx, exactly one bit set whenever out_valid=1.
- FIFO rules:
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - The head is stable while out_valid=1 and out_ready=0.
  - Output order is strictly row-major.
- Throughput:
  - Mode 0 with out_ready=1: one element per cycle.
  - Mode 1: N fetch cycles of pass 1 precede each row's N emit fetches.
  - Pass 1 of the next row may overlap the draining of the previous row's FIFO entries.
- start during MAX/EMIT/DRAIN is ignored. mode changes mid-scan are ignored.

Test Plan:
- Mode 0 boundary codes: elements -128, -1, 0, 127 -> out_idx 0, 127, 128, 255; out_match bits 0, 127, 128, 255 respectively; out_row_max=0.
- Mode 0 full scan with out_ready=1, start in cycle 0:
  - data_req high in cycles 1-256, addresses row-major (0,0)..(15,15).
  - 256 outputs, no gaps; finish=1 the cycle after the last handshake.
- Mode 1 row max, row 3 all 16 except x=5 = 48:
  - out_row_max=48.
  - x=5 -> idx 128.
  - Others: diff -32 -> idx 96.
  - Exactly 16 pass-1 requests precede row 3 emit requests.
- Mode 1 saturation: row containing 127 and -128 -> -128 element: diff -255 saturates to -128 -> idx 0, out_match bit 0.
- Backpressure: hold out_ready=0 for 10 cycles mid-EMIT:
  - At most 2 entries buffered; data_req low while occupancy is 2.
  - Head stable throughout.
  - After release, no loss or duplication, order preserved, 256 total outputs.
- Reset and restart:
  - Assert reset in the middle of row 7 pass 1 -> next cycle all outputs at reset values and FIFO empty.
  - A start pulse during a scan is ignored.
  - start from IDLE produces a complete 256-output scan ending in finish=1.

Source files
------------

// File: rtl/sasa_scan_cam_if.sv
// Fetch and result-stream bundle for the SASA scan CAM.
// master = CAM side, slave = source/consumer side.
interface sasa_scan_cam_if #(
  parameter int N      = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(N),
  parameter int MV_W   = 2**DATA_W
);
  logic              data_req;
  logic [ADDR_W-1:0] data_addr_x;
  logic [ADDR_W-1:0] data_addr_y;
  logic [DATA_W-1:0] data;
  logic              out_valid;
  logic              out_ready;
  logic [MV_W-1:0]   out_match;
  logic [DATA_W-1:0] out_idx;
  logic [ADDR_W-1:0] out_x;
  logic [ADDR_W-1:0] out_y;
  logic [DATA_W-1:0] out_row_max;

  modport master (
    output data_req,
    output data_addr_x,
    output data_addr_y,
    input  data,
    output out_valid,
    input  out_ready,
    output out_match,
    output out_idx,
    output out_x,
    output out_y,
    output out_row_max
  );

  modport slave (
    input  data_req,
    input  data_addr_x,
    input  data_addr_y,
    output data,
    input  out_valid,
    output out_ready,
    input  out_match,
    input  out_idx,
    input  out_x,
    input  out_y,
    input  out_row_max
  );
endinterface

// File: rtl/sasa_scan_cam.sv
// Row-major score-matrix scanner producing one-hot match vectors,
// optionally max-subtracted per row, through a 2-entry output FIFO.
module sasa_scan_cam #(
  parameter int N      = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(N),
  parameter int MV_W   = 2**DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  sasa_scan_cam_if.master bus,
  output logic            finish
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAX,
    S_EMIT,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] idx;
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
    logic [DATA_W-1:0] rmax;
  } ent_t;

  localparam logic [DATA_W-1:0] SMIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N-1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] rmax_q, rmax_d;
  logic              fin_q, fin_d;

  ent_t              ent_q [2];
  ent_t              ent_d [2];
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        occ_nxt;

  logic              valid;
  logic              push;
  logic              pop;
  logic [DATA_W:0]   diff;
  logic              sat;
  logic [DATA_W-1:0] diff_s;
  logic [DATA_W-1:0] idx;
  ent_t              ent_new;
  ent_t              head;

  assign valid   = cnt_q != 2'd0;
  assign push    = req_q & (state_q == S_EMIT);
  assign pop     = valid & bus.out_ready;
  assign occ_nxt = cnt_q + {1'b0, push} - {1'b0, pop};

  // diff is never positive; "10" in the top two bits means below -2^(W-1)
  always_comb begin
    diff   = {bus.data[DATA_W-1], bus.data}
           - {rmax_q[DATA_W-1], rmax_q};
    sat    = diff[DATA_W] & ~diff[DATA_W-1];
    diff_s = sat ? SMIN : diff[DATA_W-1:0];
    idx    = mode_q ? (diff_s ^ SMIN) : (bus.data ^ SMIN);
    ent_new      = '0;
    ent_new.idx  = idx;
    ent_new.x    = x_q;
    ent_new.y    = y_q;
    ent_new.rmax = mode_q ? rmax_q : '0;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    rmax_d  = rmax_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = mode;
          x_d     = '0;
          y_d     = '0;
          rmax_d  = SMIN;
          state_d = mode ? S_MAX : S_EMIT;
        end
      end
      S_MAX: begin
        if (req_q) begin
          if ($signed(bus.data) > $signed(rmax_q))
            rmax_d = bus.data;
          if (x_q == LAST) begin
            x_d     = '0;
            state_d = S_EMIT;
          end else begin
            x_d = x_q + ONE;
          end
        end
      end
      S_EMIT: begin
        if (req_q) begin
          if (x_q != LAST) begin
            x_d = x_q + ONE;
          end else begin
            x_d = '0;
            if (y_q == LAST) begin
              state_d = S_DRAIN;
            end else begin
              y_d = y_q + ONE;
              if (mode_q) begin
                state_d = S_MAX;
                rmax_d  = SMIN;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (occ_nxt == 2'd0)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // request only when the FIFO can absorb the capture next edge
    req_d = (state_d == S_MAX)
          | ((state_d == S_EMIT) & (occ_nxt <= 2'd1));
    fin_d = state_d == S_DONE;
  end

  always_comb begin
    ent_d = ent_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = occ_nxt;
    if (push) begin
      ent_d[wr_q] = ent_new;
      wr_d        = ~wr_q;
    end
    if (pop)
      rd_d = ~rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rmax_q  <= '0;
      fin_q   <= 1'b0;
      ent_q   <= '{default: '0};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      req_q   <= req_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rmax_q  <= rmax_d;
      fin_q   <= fin_d;
      ent_q   <= ent_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head            = ent_q[rd_q];
  assign bus.data_req    = req_q;
  assign bus.data_addr_x = x_q;
  assign bus.data_addr_y = y_q;
  assign bus.out_valid   = valid;
  assign bus.out_idx     = head.idx;
  assign bus.out_x       = head.x;
  assign bus.out_y       = head.y;
  assign bus.out_row_max = head.rmax;
  assign bus.out_match   =
    valid ? (MV_W'(1) << head.idx) : '0;
  assign finish          = fin_q;

endmodule

// File: tb/tb_sasa_scan_cam.sv
// Randomised bench for sasa_scan_cam against a row-wise
// behavioural model of the match-index rules.
module tb_sasa_scan_cam;

  typedef struct packed {
    logic [7:0]   idx;
    logic [255:0] mt;
    logic [3:0]   x;
    logic [3:0]   y;
    logic [7:0]   rm;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic finish;

  sasa_scan_cam_if bus ();

  sasa_scan_cam dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .bus   (bus.master),
    .finish(finish)
  );

  logic signed [7:0] mat [16][16];
  assign bus.data = mat[bus.data_addr_y][bus.data_addr_x];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  logic [7:0] req_q[$];
  int first_req, last_req, nreq, nhs, fin_cyc, last_hs;
  int gaps, occ_viol, head_viol, stall_cnt;
  bit prev_stall, chk_occ;
  rec_t prev_rec, cur;
  int hold_lo = -1;
  int hold_len = 0;
  bit rnd_rdy = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (cyc >= hold_lo && cyc < hold_lo + hold_len)
      bus.out_ready = 1'b0;
  end

  always @(negedge clk) begin
    cur = {bus.out_idx, bus.out_match, bus.out_x,
           bus.out_y, bus.out_row_max};
    if (chk_occ && ((nreq - nhs > 2) ||
        (nreq - nhs == 2 && bus.data_req)))
      occ_viol++;
    if (prev_stall && bus.out_valid && cur !== prev_rec)
      head_viol++;
    prev_stall = bus.out_valid && !bus.out_ready;
    if (prev_stall) stall_cnt++;
    prev_rec = cur;
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(cur);
      if (last_hs >= 0 && cyc != last_hs + 1) gaps++;
      last_hs = cyc;
      nhs++;
    end
    if (bus.data_req) begin
      req_q.push_back({bus.data_addr_y, bus.data_addr_x});
      if (first_req < 0) first_req = cyc;
      last_req = cyc;
      nreq++;
    end
    if (finish && fin_cyc < 0) fin_cyc = cyc;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    got_q.delete();
    req_q.delete();
    first_req = -1; last_req = -1; fin_cyc = -1; last_hs = -1;
    nreq = 0; nhs = 0; gaps = 0; occ_viol = 0;
    head_viol = 0; stall_cnt = 0; prev_stall = 0;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mat[r][c] = 8'($urandom);
  endtask

  // Row maximum, then each element mapped by the index rules.
  task automatic build_exp(input bit m);
    exp_q.delete();
    for (int r = 0; r < 16; r++) begin
      int mx;
      mx = -128;
      if (m)
        for (int c = 0; c < 16; c++)
          if (int'(mat[r][c]) > mx) mx = int'(mat[r][c]);
      for (int c = 0; c < 16; c++) begin
        int d;
        rec_t e;
        d = int'(mat[r][c]);
        if (m) begin
          d = d - mx;
          if (d < -128) d = -128;
        end
        e.idx = 8'(d + 128);
        e.mt  = 256'(1) << (d + 128);
        e.x   = 4'(c);
        e.y   = 4'(r);
        e.rm  = m ? 8'(mx) : 8'd0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_scan(input bit m, input bit poke, output bit tmo);
    @(posedge clk); #1;
    clear_mon();
    mode = m;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (poke && i == 100) begin
        start = 1'b1;
        mode = ~m;
      end
      if (poke && i == 101) start = 1'b0;
      if (finish) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [255:0] v [10];
    reset = 1'b1; start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    v[0] = 256'(bus.data_req);   v[1] = 256'(bus.data_addr_x);
    v[2] = 256'(bus.data_addr_y); v[3] = 256'(bus.out_valid);
    v[4] = bus.out_match;          v[5] = 256'(bus.out_idx);
    v[6] = 256'(bus.out_x);        v[7] = 256'(bus.out_y);
    v[8] = 256'(bus.out_row_max);  v[9] = 256'(finish);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (v[i] !== '0) begin
        errors++;
        $display("FAIL reset_out[%0d] got %h want 0", i, v[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.data_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored data_req=%b want 0", bus.data_req);
    end
  endtask

  task automatic test_mode0_full();
    bit tmo;
    int bad;
    logic [7:0] want_idx [4];
    want_idx[0] = 8'd0;   want_idx[1] = 8'd127;
    want_idx[2] = 8'd128; want_idx[3] = 8'd255;
    fill_rand();
    mat[0][0] = -8'sd128; mat[0][1] = -8'sd1;
    mat[0][2] = 8'sd0;    mat[0][3] = 8'sd127;
    build_exp(1'b0);
    run_scan(1'b0, 1'b0, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL m0_timeout got 1 want 0"); end
    checks++;
    if (got_q.size() != 256) begin
      errors++; $display("FAIL m0_count got %0d want 256", got_q.size());
    end
    for (int i = 0; i < 256 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL m0_elem[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].idx !== want_idx[i] || got_q[i].rm !== 8'd0 ||
          got_q[i].mt !== (256'(1) << want_idx[i])) begin
        errors++;
        $display("FAIL m0_boundary[%0d] got idx=%0d rm=%0d want idx=%0d rm=0",
                 i, got_q[i].idx, got_q[i].rm, want_idx[i]);
      end
    end
    checks++;
    if (first_req != start_cyc + 1 || last_req != start_cyc + 256) begin
      errors++;
      $display("FAIL m0_req_window got %0d..%0d want %0d..%0d",
               first_req, last_req, start_cyc + 1, start_cyc + 256);
    end
    checks++;
    bad = (req_q.size() != 256) ? 1 : 0;
    for (int i = 0; i < req_q.size(); i++)
      if (req_q[i] !== 8'(i)) bad++;
    if (bad != 0) begin
      errors++; $display("FAIL m0_req_order got %0d bad want 0", bad);
    end
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL m0_gaps got %0d want 0", gaps);
    end
    checks++;
    if (fin_cyc != start_cyc + 258) begin
      errors++;
      $display("FAIL m0_finish_cycle got %0d want %0d", fin_cyc, start_cyc + 258);
    end
  endtask

  task automatic test_mode1_rowmax();
    bit tmo;
    int bad;
    fill_rand();
    for (int c = 0; c < 16; c++) mat[3][c] = 8'sd16;
    mat[3][5] = 8'sd48;
    build_exp(1'b1);
    run_scan(1'b1, 1'b0, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL m1_timeout got 1 want 0"); end
    checks++;
    if (got_q.size() != 256) begin
      errors++; $display("FAIL m1_count got %0d want 256", got_q.size());
    end
    for (int i = 0; i < 256 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL m1_elem[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 256) begin
      checks++;
      if (got_q[53].rm !== 8'd48 || got_q[53].idx !== 8'd128) begin
        errors++;
        $display("FAIL m1_row3_max got rm=%0d idx=%0d want rm=48 idx=128",
                 got_q[53].rm, got_q[53].idx);
      end
      checks++;
      if (got_q[48].idx !== 8'd96 || got_q[63].idx !== 8'd96) begin
        errors++;
        $display("FAIL m1_row3_other got %0d,%0d want 96,96",
                 got_q[48].idx, got_q[63].idx);
      end
    end
    checks++;
    if (nreq != 512) begin
      errors++; $display("FAIL m1_req_total got %0d want 512", nreq);
    end
    checks++;
    bad = (req_q.size() < 128) ? 1 : 0;
    for (int k = 0; k < 32 && req_q.size() >= 128; k++)
      if (req_q[96 + k] !== {4'd3, 4'(k % 16)}) bad++;
    if (bad != 0) begin
      errors++; $display("FAIL m1_row3_pass1 got %0d bad want 0", bad);
    end
  endtask

  task automatic test_saturation();
    bit tmo;
    fill_rand();
    mat[0][0] = 8'sd127;
    mat[0][9] = -8'sd128;
    build_exp(1'b1);
    run_scan(1'b1, 1'b0, tmo);
    checks++;
    if (tmo || got_q.size() != 256) begin
      errors++;
      $display("FAIL sat_run got tmo=%0d n=%0d want 0,256", tmo, got_q.size());
    end
    if (got_q.size() > 9) begin
      checks++;
      if (got_q[9].idx !== 8'd0 || got_q[9].mt !== 256'd1 ||
          got_q[9].rm !== 8'd127) begin
        errors++;
        $display("FAIL sat_elem got idx=%0d rm=%0d want idx=0 rm=127",
                 got_q[9].idx, got_q[9].rm);
      end
    end
    for (int i = 0; i < 256 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sat_elem[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit tmo;
    fill_rand();
    build_exp(1'b0);
    chk_occ = 1'b1;
    hold_lo = cyc + 45;
    hold_len = 10;
    run_scan(1'b0, 1'b0, tmo);
    chk_occ = 1'b0;
    hold_lo = -1;
    hold_len = 0;
    checks++;
    if (tmo || got_q.size() != 256 || nreq != 256) begin
      errors++;
      $display("FAIL bp_run got tmo=%0d n=%0d req=%0d want 0,256,256",
               tmo, got_q.size(), nreq);
    end
    for (int i = 0; i < 256 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_elem[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (occ_viol != 0) begin
      errors++; $display("FAIL bp_occupancy got %0d want 0", occ_viol);
    end
    checks++;
    if (head_viol != 0) begin
      errors++; $display("FAIL bp_head_stable got %0d want 0", head_viol);
    end
    checks++;
    if (stall_cnt < 10) begin
      errors++; $display("FAIL bp_stalled got %0d want >=10", stall_cnt);
    end
  endtask

  task automatic test_random_ready();
    bit tmo;
    fill_rand();
    build_exp(1'b1);
    rnd_rdy = 1'b1;
    run_scan(1'b1, 1'b1, tmo);
    rnd_rdy = 1'b0;
    checks++;
    if (tmo || got_q.size() != 256 || nreq != 512) begin
      errors++;
      $display("FAIL rr_run got tmo=%0d n=%0d req=%0d want 0,256,512",
               tmo, got_q.size(), nreq);
    end
    for (int i = 0; i < 256 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rr_elem[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (head_viol != 0) begin
      errors++; $display("FAIL rr_head_stable got %0d want 0", head_viol);
    end
  endtask

  task automatic test_reset_restart();
    bit tmo;
    logic [255:0] v [10];
    fill_rand();
    @(posedge clk); #1;
    mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (bus.data_req && bus.data_addr_y == 4'd7) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (tmo) begin errors++; $display("FAIL rst_reach_row7 got timeout"); end
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    v[0] = 256'(bus.data_req);   v[1] = 256'(bus.data_addr_x);
    v[2] = 256'(bus.data_addr_y); v[3] = 256'(bus.out_valid);
    v[4] = bus.out_match;          v[5] = 256'(bus.out_idx);
    v[6] = 256'(bus.out_x);        v[7] = 256'(bus.out_y);
    v[8] = 256'(bus.out_row_max);  v[9] = 256'(finish);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (v[i] !== '0) begin
        errors++;
        $display("FAIL rst_mid_out[%0d] got %h want 0", i, v[i]);
      end
    end
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (bus.data_req !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_resume got req=%b valid=%b want 0,0",
               bus.data_req, bus.out_valid);
    end
    build_exp(1'b0);
    run_scan(1'b0, 1'b0, tmo);
    checks++;
    if (tmo || got_q.size() != 256 || finish !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart got tmo=%0d n=%0d fin=%b want 0,256,1",
               tmo, got_q.size(), finish);
    end
    for (int i = 0; i < 256 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_elem[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    clear_mon();
    chk_occ = 1'b0;
    test_reset();
    test_mode0_full();
    test_mode1_rowmax();
    test_saturation();
    test_backpressure();
    test_random_ready();
    test_reset_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
